ccu_snoop_port_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the CCU's single snoop master port (AC/CR/CD) between `NumReq` snoop-initiating controllers, such as the read-snoop and write-snoop FSMs. It sits between those controllers and the snoop crossbar. It grants one requester at a time and locks the port to it until that snoop transaction completes, so CR and CD beats always return to the controller that issued the AC.

---
 rtl/ccu_snoop_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ccu_snoop_port_arbiter.sv | 537 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccu_snoop_port_arbiter.sv
// Snoop port arbiter: shares the CCU's single AC/CR/CD snoop master port
// between NumReq snoop-initiating controllers. One requester is granted
// round-robin and keeps the port until its snoop transaction completes,
// so CR and CD beats always return to the controller that issued the AC.
module ccu_snoop_port_arbiter #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    localparam int unsigned IdxW     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    // requester-side AC
    input  logic [NumReq-1:0]                   s_ac_valid_i,
    output logic [NumReq-1:0]                   s_ac_ready_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]    s_ac_addr_i,
    input  logic [NumReq-1:0][3:0]              s_ac_snoop_i,
    input  logic [NumReq-1:0][2:0]              s_ac_prot_i,
    // requester-side CR
    output logic [NumReq-1:0]                   s_cr_valid_o,
    input  logic [NumReq-1:0]                   s_cr_ready_i,
    output logic [4:0]                          s_cr_resp_o,
    // requester-side CD
    output logic [NumReq-1:0]                   s_cd_valid_o,
    input  logic [NumReq-1:0]                   s_cd_ready_i,
    output logic [DataWidth-1:0]                s_cd_data_o,
    output logic                                s_cd_last_o,
    // crossbar-side AC
    output logic                                m_ac_valid_o,
    input  logic                                m_ac_ready_i,
    output logic [AddrWidth-1:0]                m_ac_addr_o,
    output logic [3:0]                          m_ac_snoop_o,
    output logic [2:0]                          m_ac_prot_o,
    // crossbar-side CR
    input  logic                                m_cr_valid_i,
    output logic                                m_cr_ready_o,
    input  logic [4:0]                          m_cr_resp_i,
    // crossbar-side CD
    input  logic                                m_cd_valid_i,
    output logic                                m_cd_ready_o,
    input  logic [DataWidth-1:0]                m_cd_data_i,
    input  logic                                m_cd_last_i,
    // status
    output logic [IdxW-1:0]                     owner_o,
    output logic                                busy_o
);

    localparam int unsigned CandW = IdxW + 1;
    typedef logic [CandW-1:0] cand_t;

    typedef enum logic [1:0] {
        StIdle,
        StAc,
        StCr,
        StCd
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] prio_q,  prio_d;
    logic [IdxW-1:0] next_owner;

    logic            grant_vld;
    logic [IdxW-1:0] grant_idx;
    cand_t           cand;

    // State, owner and round-robin pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            owner_q <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

    // Round-robin pick: first valid requester at or after prio_q, with
    // explicit wrap so NumReq need not be a power of two
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = {1'b0, prio_q} + cand_t'(i);
            if (cand >= cand_t'(NumReq)) begin
                cand = cand - cand_t'(NumReq);
            end
            if (!grant_vld && s_ac_valid_i[cand[IdxW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IdxW-1:0];
            end
        end
    end

    assign next_owner = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + IdxW'(1);

    // Next-state logic and per-channel routing to/from the locked owner
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        prio_d       = prio_q;
        s_ac_ready_o = '0;
        s_cr_valid_o = '0;
        s_cd_valid_o = '0;
        m_ac_valid_o = 1'b0;
        m_cr_ready_o = 1'b0;
        m_cd_ready_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    owner_d = grant_idx;
                    state_d = StAc;
                end
            end
            StAc: begin
                m_ac_valid_o          = s_ac_valid_i[owner_q];
                s_ac_ready_o[owner_q] = m_ac_ready_i;
                if (s_ac_valid_i[owner_q] && m_ac_ready_i) begin
                    state_d = StCr;
                end
            end
            StCr: begin
                s_cr_valid_o[owner_q] = m_cr_valid_i;
                m_cr_ready_o          = s_cr_ready_i[owner_q];
                if (m_cr_valid_i && s_cr_ready_i[owner_q]) begin
                    // DataTransfer forces the CD phase even with Error set;
                    // the owner decides whether to discard the beats
                    if (m_cr_resp_i[0]) begin
                        state_d = StCd;
                    end else begin
                        state_d = StIdle;
                        prio_d  = next_owner;
                    end
                end
            end
            StCd: begin
                s_cd_valid_o[owner_q] = m_cd_valid_i;
                m_cd_ready_o          = s_cd_ready_i[owner_q];
                if (m_cd_valid_i && s_cd_ready_i[owner_q] && m_cd_last_i) begin
                    state_d = StIdle;
                    prio_d  = next_owner;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign m_ac_addr_o  = s_ac_addr_i[owner_q];
    assign m_ac_snoop_o = s_ac_snoop_i[owner_q];
    assign m_ac_prot_o  = s_ac_prot_i[owner_q];
    assign s_cr_resp_o  = m_cr_resp_i;
    assign s_cd_data_o  = m_cd_data_i;
    assign s_cd_last_o  = m_cd_last_i;
    assign owner_o      = owner_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_ccu_snoop_port_arbiter.sv
// Bench for ccu_snoop_port_arbiter: random requester traffic and a crossbar
// model, checked through scoreboards against a round-robin grant model.
module tb_ccu_snoop_port_arbiter;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NR-1:0]          s_ac_valid_i = '0;
    logic [NR-1:0]          s_ac_ready_o;
    logic [NR-1:0][AW-1:0]  s_ac_addr_i = '0;
    logic [NR-1:0][3:0]     s_ac_snoop_i = '0;
    logic [NR-1:0][2:0]     s_ac_prot_i = '0;
    logic [NR-1:0]          s_cr_valid_o;
    logic [NR-1:0]          s_cr_ready_i = '0;
    logic [4:0]             s_cr_resp_o;
    logic [NR-1:0]          s_cd_valid_o;
    logic [NR-1:0]          s_cd_ready_i = '0;
    logic [DW-1:0]          s_cd_data_o;
    logic                   s_cd_last_o;
    logic                   m_ac_valid_o;
    logic                   m_ac_ready_i = 1'b0;
    logic [AW-1:0]          m_ac_addr_o;
    logic [3:0]             m_ac_snoop_o;
    logic [2:0]             m_ac_prot_o;
    logic                   m_cr_valid_i = 1'b0;
    logic                   m_cr_ready_o;
    logic [4:0]             m_cr_resp_i = '0;
    logic                   m_cd_valid_i = 1'b0;
    logic                   m_cd_ready_o;
    logic [DW-1:0]          m_cd_data_i = '0;
    logic                   m_cd_last_i = 1'b0;
    logic [IW-1:0]          owner_o;
    logic                   busy_o;

    always #5 clk = ~clk;

    ccu_snoop_port_arbiter #(
        .NumReq   (NR),
        .AddrWidth(AW),
        .DataWidth(DW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .s_ac_valid_i(s_ac_valid_i),
        .s_ac_ready_o(s_ac_ready_o),
        .s_ac_addr_i (s_ac_addr_i),
        .s_ac_snoop_i(s_ac_snoop_i),
        .s_ac_prot_i (s_ac_prot_i),
        .s_cr_valid_o(s_cr_valid_o),
        .s_cr_ready_i(s_cr_ready_i),
        .s_cr_resp_o (s_cr_resp_o),
        .s_cd_valid_o(s_cd_valid_o),
        .s_cd_ready_i(s_cd_ready_i),
        .s_cd_data_o (s_cd_data_o),
        .s_cd_last_o (s_cd_last_o),
        .m_ac_valid_o(m_ac_valid_o),
        .m_ac_ready_i(m_ac_ready_i),
        .m_ac_addr_o (m_ac_addr_o),
        .m_ac_snoop_o(m_ac_snoop_o),
        .m_ac_prot_o (m_ac_prot_o),
        .m_cr_valid_i(m_cr_valid_i),
        .m_cr_ready_o(m_cr_ready_o),
        .m_cr_resp_i (m_cr_resp_i),
        .m_cd_valid_i(m_cd_valid_i),
        .m_cd_ready_o(m_cd_ready_o),
        .m_cd_data_i (m_cd_data_i),
        .m_cd_last_i (m_cd_last_i),
        .owner_o     (owner_o),
        .busy_o      (busy_o)
    );

    typedef struct {
        int            idx;
        logic [AW-1:0] addr;
        logic [3:0]    snoop;
        logic [2:0]    prot;
    } ac_t;

    typedef struct {
        logic [4:0]    resp;
        int            nb;
        logic [DW-1:0] base;
    } xb_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } cd_t;

    ac_t        rq[NR][$];
    ac_t        exp_ac[$];
    logic [4:0] exp_cr[$];
    cd_t        exp_cd[$];
    xb_t        xb_cfg[$];

    int checks = 0;
    int errors = 0;
    int model_prio = 0;
    int cur_owner = -1;
    bit mon_en = 1'b0;
    bit rdy_rand = 1'b1;
    int cyc = 0;
    int done_cyc = 0;
    bit pend_chk = 1'b0;
    logic prev_acv = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
    endtask

    task automatic chk_all_idle(input string name);
        chk({name, "_ac_ready"}, s_ac_ready_o, 0);
        chk({name, "_cr_valid"}, s_cr_valid_o, 0);
        chk({name, "_cd_valid"}, s_cd_valid_o, 0);
        chk({name, "_m_ac_valid"}, m_ac_valid_o, 0);
        chk({name, "_m_cr_ready"}, m_cr_ready_o, 0);
        chk({name, "_m_cd_ready"}, m_cd_ready_o, 0);
        chk({name, "_busy"}, busy_o, 0);
        chk({name, "_owner"}, owner_o, 0);
    endtask

    task automatic add_req(input int i, input logic [AW-1:0] a, input logic [3:0] s, input logic [2:0] p);
        ac_t e;
        e.idx = i; e.addr = a; e.snoop = s; e.prot = p;
        rq[i].push_back(e);
    endtask

    // Reference model: with every pending requester holding valid, grants
    // follow plain round-robin over requesters that still have work.
    task automatic plan_batch(output int n);
        int left[NR];
        int taken[NR];
        int p;
        n = 0;
        p = model_prio;
        for (int i = 0; i < NR; i++) begin
            left[i] = rq[i].size();
            taken[i] = 0;
            n += left[i];
        end
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (p + k) % NR;
                if (left[j] > 0) begin
                    exp_ac.push_back(rq[j][taken[j]]);
                    left[j]--;
                    taken[j]++;
                    p = (j + 1) % NR;
                    break;
                end
            end
        end
        model_prio = p;
    endtask

    task automatic load_payload(input int i);
        s_ac_addr_i[i]  = rq[i][0].addr;
        s_ac_snoop_i[i] = rq[i][0].snoop;
        s_ac_prot_i[i]  = rq[i][0].prot;
        s_ac_valid_i[i] = 1'b1;
    endtask

    task automatic drive_reqs(input int n);
        int got;
        int c;
        logic [NR-1:0] hs;
        got = 0;
        c = 0;
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) load_payload(i);
            else s_ac_valid_i[i] = 1'b0;
        end
        while (got < n && c < 600) begin
            @(negedge clk);
            if (c == 0) begin
                chk("arb_cycle_m_ac_valid", m_ac_valid_o, 0);
                chk("arb_cycle_busy", busy_o, 0);
            end else if (c == 1) begin
                chk("grant_latency_m_ac_valid", m_ac_valid_o, 1);
                chk("grant_latency_busy", busy_o, 1);
            end
            hs = s_ac_valid_i & s_ac_ready_o;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (hs[i]) begin
                    got++;
                    void'(rq[i].pop_front());
                    if (rq[i].size() > 0) load_payload(i);
                    else s_ac_valid_i[i] = 1'b0;
                end
            end
            c++;
        end
        if (got < n) fail("requester_ac_timeout");
    endtask

    task automatic wait_gap();
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Crossbar model: accepts AC, returns CR and optional CD burst; drives a
    // stray CD beat while waiting for AC, which must never be accepted.
    task automatic xb_run(input int n);
        xb_t cfg;
        int c;
        for (int t = 0; t < n; t++) begin
            if (xb_cfg.size() > 0) cfg = xb_cfg.pop_front();
            else begin
                cfg.resp = 5'($urandom);
                cfg.nb   = $urandom_range(1, 4);
                cfg.base = $urandom;
            end
            m_cd_valid_i = 1'b1;
            m_cd_data_i  = $urandom;
            m_cd_last_i  = 1'($urandom);
            m_ac_ready_i = 1'($urandom);
            c = 0;
            forever begin
                @(negedge clk);
                chk("stray_cd_not_consumed", m_cd_ready_o, 0);
                if (m_ac_valid_o && m_ac_ready_i) break;
                if (++c > 300) begin
                    fail("xb_ac_timeout");
                    m_cd_valid_i = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
                m_ac_ready_i = 1'($urandom);
            end
            @(posedge clk);
            #1;
            m_ac_ready_i = 1'b0;
            m_cd_valid_i = 1'b0;
            m_cd_last_i  = 1'b0;
            wait_gap();
            m_cr_valid_i = 1'b1;
            m_cr_resp_i  = cfg.resp;
            exp_cr.push_back(cfg.resp);
            c = 0;
            forever begin
                @(negedge clk);
                if (m_cr_ready_o) break;
                if (++c > 300) begin
                    fail("xb_cr_timeout");
                    m_cr_valid_i = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
            m_cr_valid_i = 1'b0;
            if (cfg.resp[0]) begin
                for (int b = 0; b < cfg.nb; b++) begin
                    cd_t d;
                    wait_gap();
                    d.data = cfg.base + DW'(b);
                    d.last = (b == cfg.nb - 1);
                    m_cd_valid_i = 1'b1;
                    m_cd_data_i  = d.data;
                    m_cd_last_i  = d.last;
                    exp_cd.push_back(d);
                    c = 0;
                    forever begin
                        @(negedge clk);
                        if (m_cd_ready_o) break;
                        if (++c > 300) begin
                            fail("xb_cd_timeout");
                            m_cd_valid_i = 1'b0;
                            return;
                        end
                    end
                    @(posedge clk);
                    #1;
                    m_cd_valid_i = 1'b0;
                    m_cd_last_i  = 1'b0;
                end
            end
        end
    endtask

    task automatic run_batch();
        int n;
        plan_batch(n);
        mon_en = 1'b1;
        fork
            drive_reqs(n);
            xb_run(n);
        join
        repeat (2) @(posedge clk);
        #1;
        chk("sb_ac_drained", exp_ac.size(), 0);
        chk("sb_cr_drained", exp_cr.size(), 0);
        chk("sb_cd_drained", exp_cd.size(), 0);
        xb_cfg.delete();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n = 1'b0;
        s_ac_valid_i = '0;
        m_ac_ready_i = 1'b0;
        m_cr_valid_i = 1'b0;
        m_cd_valid_i = 1'b0;
        m_cd_last_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_idle("in_reset");
        rst_n = 1'b1;
        model_prio = 0;
        cur_owner = -1;
        pend_chk = 1'b0;
        for (int i = 0; i < NR; i++) rq[i].delete();
        exp_ac.delete();
        exp_cr.delete();
        exp_cd.delete();
        xb_cfg.delete();
    endtask

    // Requester-side response backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) begin
                s_cr_ready_i = NR'($urandom);
                s_cd_ready_i = NR'($urandom);
            end
        end
    end

    // Monitor: pops scoreboards on requester-side handshakes, checks that
    // non-owners never see valid/ready, and checks re-grant latency.
    always @(negedge clk) begin
        logic [NR-1:0] mask;
        cyc++;
        if (mon_en && rst_n) begin
            if (m_ac_valid_o && !prev_acv && pend_chk) begin
                chk("regrant_latency", 64'(cyc - done_cyc), 2);
                pend_chk = 1'b0;
            end
            prev_acv = m_ac_valid_o;

            mask = busy_o ? (NR'(1) << owner_o) : '0;
            chk("nonowner_ac_ready", s_ac_ready_o & ~mask, 0);
            chk("nonowner_cr_valid", s_cr_valid_o & ~mask, 0);
            chk("nonowner_cd_valid", s_cd_valid_o & ~mask, 0);
            if (!busy_o) chk("idle_m_side_quiet", {m_ac_valid_o, m_cr_ready_o, m_cd_ready_o}, 0);

            for (int i = 0; i < NR; i++) begin
                if (s_ac_valid_i[i] && s_ac_ready_o[i]) begin
                    if (exp_ac.size() == 0) fail("ac_unexpected");
                    else begin
                        ac_t e;
                        e = exp_ac.pop_front();
                        chk("grant_order", i, e.idx);
                        chk("ac_owner_o", owner_o, e.idx);
                        chk("ac_m_valid", m_ac_valid_o, 1);
                        chk("ac_addr", m_ac_addr_o, e.addr);
                        chk("ac_snoop", m_ac_snoop_o, e.snoop);
                        chk("ac_prot", m_ac_prot_o, e.prot);
                        cur_owner = e.idx;
                    end
                end
                if (s_cr_valid_o[i] && s_cr_ready_i[i]) begin
                    if (exp_cr.size() == 0) fail("cr_unexpected");
                    else begin
                        logic [4:0] r;
                        r = exp_cr.pop_front();
                        chk("cr_dest", i, cur_owner);
                        chk("cr_resp", s_cr_resp_o, r);
                        if (!r[0]) begin
                            done_cyc = cyc;
                            pend_chk = (exp_ac.size() > 0);
                        end
                    end
                end
                if (s_cd_valid_o[i] && s_cd_ready_i[i]) begin
                    if (exp_cd.size() == 0) fail("cd_unexpected");
                    else begin
                        cd_t d;
                        d = exp_cd.pop_front();
                        chk("cd_dest", i, cur_owner);
                        chk("cd_data", s_cd_data_o, d.data);
                        chk("cd_last", s_cd_last_o, d.last);
                        if (d.last) begin
                            done_cyc = cyc;
                            pend_chk = (exp_ac.size() > 0);
                        end
                    end
                end
            end
        end else begin
            prev_acv = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        #3;
        chk_all_idle("por_reset");
        do_reset();

        // single request, no data
        add_req(0, 32'h1000, 4'h1, 3'h0);
        xb_cfg.push_back('{5'b00000, 0, 32'h0});
        run_batch();

        // simultaneous requests after reset: req0 then req1
        do_reset();
        add_req(0, 32'h2000, 4'h2, 3'h1);
        add_req(1, 32'h3000, 4'h3, 3'h2);
        run_batch();

        // data transfer to req1 with backpressure
        add_req(1, 32'h4000, 4'h7, 3'h3);
        xb_cfg.push_back('{5'b01001, 4, 32'hA0});
        run_batch();

        // error with DataTransfer still forwards the burst
        add_req(2, 32'h5000, 4'h9, 3'h4);
        xb_cfg.push_back('{5'b00011, 4, 32'hB0});
        run_batch();

        // fairness: all requesters busy, 6 transactions
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NR; i++)
                add_req(i, AW'($urandom), 4'($urandom), 3'($urandom));
        run_batch();

        // randomized batches
        repeat (12) begin
            int tot;
            tot = 0;
            for (int i = 0; i < NR; i++) begin
                int m;
                m = $urandom_range(0, 2);
                tot += m;
                repeat (m) add_req(i, AW'($urandom), 4'($urandom), 3'($urandom));
            end
            if (tot == 0) add_req($urandom_range(0, NR - 1), AW'($urandom), 4'h1, 3'h0);
            run_batch();
        end

        // reset during CD: owner 1 mid-burst, then next grant must be 0
        do_reset();
        rdy_rand = 1'b0;
        s_cr_ready_i = '1;
        s_cd_ready_i = '1;
        s_ac_addr_i[1] = 32'h6000;
        s_ac_valid_i = 3'b010;
        m_ac_ready_i = 1'b1;
        c = 0;
        forever begin
            @(negedge clk);
            if (m_ac_valid_o) break;
            if (++c > 10) begin
                fail("rst_test_grant_timeout");
                break;
            end
        end
        chk("rst_test_owner", owner_o, 1);
        @(posedge clk);
        #1;
        s_ac_valid_i = '0;
        m_ac_ready_i = 1'b0;
        m_cr_valid_i = 1'b1;
        m_cr_resp_i = 5'b00001;
        @(negedge clk);
        chk("rst_test_cr_route", s_cr_valid_o, 3'b010);
        @(posedge clk);
        #1;
        m_cr_valid_i = 1'b0;
        m_cd_valid_i = 1'b1;
        m_cd_data_i = 32'hC0;
        m_cd_last_i = 1'b0;
        @(negedge clk);
        chk("rst_test_cd_route", s_cd_valid_o, 3'b010);
        chk("rst_test_cd_ready", m_cd_ready_o, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_idle("async_reset_mid_cd");
        @(posedge clk);
        #1;
        m_cd_valid_i = 1'b0;
        rst_n = 1'b1;
        s_ac_valid_i = '1;
        @(negedge clk);
        chk("post_reset_arb_cycle", m_ac_valid_o, 0);
        @(negedge clk);
        chk("post_reset_busy", busy_o, 1);
        chk("post_reset_owner", owner_o, 0);
        rdy_rand = 1'b1;
        do_reset();

        repeat (3) begin
            for (int i = 0; i < NR; i++)
                repeat ($urandom_range(1, 2)) add_req(i, AW'($urandom), 4'($urandom), 3'($urandom));
            run_batch();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
